// File: rtl/tri_bus_rd_pkg.sv
// Shared definitions for the tri_bus_rd read-side bus controller.
// TRI_BUS_RD_SYNC_EN adds a 2-flop input synchronizer and two extra access cycles.
package tri_bus_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REL  = 3'd1,
    ST_ACC  = 3'd2,
    ST_CAPT = 3'd3,
    ST_RET  = 3'd4
  } state_e;

  localparam int TURN_CYC_DEF = 2;
  localparam int CNT_W_MIN    = 4;

`ifdef TRI_BUS_RD_SYNC_EN
  localparam int SYNC_XTRA = 2;
`else
  localparam int SYNC_XTRA = 0;
`endif

  // One extra bit when the synchronizer stretches the access phase past 2^WAIT_W-1.
  function automatic int cnt_width(input int wait_w);
    int w;
    w = (wait_w > CNT_W_MIN) ? wait_w : CNT_W_MIN;
    return (SYNC_XTRA != 0) ? w + 1 : w;
  endfunction

endpackage

// File: rtl/tri_bus_rd_cnt.sv
// Loadable down-counter with zero flag; times both turnaround and access phases.
module tri_bus_rd_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tri_bus_rd.sv
// Read-side controller for a shared tri-state bus: release, turnaround, access, capture.
// Optional macro TRI_BUS_RD_SYNC_EN: bus_in goes through a 2-flop synchronizer.
import tri_bus_rd_pkg::*;

module tri_bus_rd #(
  parameter int WIDTH    = 32,
  parameter int TURN_CYC = TURN_CYC_DEF,
  parameter int WAIT_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  output logic             req_ack,
  input  logic [WAIT_W-1:0] wait_cfg,
  input  logic [WIDTH-1:0] bus_in,
  output logic             drv_en,
  output logic             dev_oe,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  input  logic             rready,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WAIT_W);

  state_e            state_q;
  logic [WAIT_W-1:0] wcfg_q;
  logic              req_ack_q, drv_en_q, dev_oe_q, rvalid_q, busy_q;
  logic [WIDTH-1:0]  rdata_q;
  logic [WIDTH-1:0]  cap_src;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_val;
  logic              accept;

  // Unread data blocks a new request unless it is being consumed this very cycle.
  assign accept = req && (!rvalid_q || rready);

`ifdef TRI_BUS_RD_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    sync1_q <= bus_in;
    sync2_q <= sync1_q;
  end

  assign cap_src = sync2_q;
`else
  assign cap_src = bus_in;
`endif

  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: begin
        cnt_load = accept;
        cnt_val  = CNT_W'(TURN_CYC - 1);
      end
      ST_REL: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(wcfg_q) + CNT_W'(SYNC_XTRA);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_ACC:  cnt_dec = 1'b1;
      ST_CAPT: begin
        cnt_load = 1'b1;
        cnt_val  = CNT_W'(TURN_CYC - 1);
      end
      ST_RET:  cnt_dec = 1'b1;
      default: cnt_dec = 1'b0;
    endcase
  end

  tri_bus_rd_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wcfg_q    <= '0;
      req_ack_q <= 1'b0;
      drv_en_q  <= 1'b1;
      dev_oe_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      req_ack_q <= 1'b0;
      if (rvalid_q && rready)
        rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_ack_q <= 1'b1;
            wcfg_q    <= wait_cfg;
            drv_en_q  <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_REL;
          end
        end
        ST_REL: begin
          if (cnt_zero) begin
            dev_oe_q <= 1'b1;
            state_q  <= ST_ACC;
          end
        end
        ST_ACC: begin
          if (cnt_zero)
            state_q <= ST_CAPT;
        end
        ST_CAPT: begin
          rdata_q  <= cap_src;
          rvalid_q <= 1'b1;
          dev_oe_q <= 1'b0;
          state_q  <= ST_RET;
        end
        ST_RET: begin
          if (cnt_zero) begin
            drv_en_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ack = req_ack_q;
  assign drv_en  = drv_en_q;
  assign dev_oe  = dev_oe_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_tri_bus_rd.sv
// Randomized self-checking bench for tri_bus_rd with a cycle-history reference model.
// Honours TRI_BUS_RD_SYNC_EN for expected latency and capture point.
module tb_tri_bus_rd;

  localparam int WIDTH  = 32;
  localparam int TURN   = 2;
  localparam int WAIT_W = 4;
`ifdef TRI_BUS_RD_SYNC_EN
  localparam int SDLY = 2;
`else
  localparam int SDLY = 0;
`endif
  localparam logic [WIDTH-1:0] BUS_PARK = 32'hDEAD_BEEF;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req = 1'b0;
  logic              rready = 1'b0;
  logic [WAIT_W-1:0] wait_cfg = '0;
  logic [WIDTH-1:0]  bus_in = BUS_PARK;
  logic              req_ack, drv_en, dev_oe, rvalid, busy;
  logic [WIDTH-1:0]  rdata;

  always #5 clk = ~clk;

  tri_bus_rd #(.WIDTH(WIDTH), .TURN_CYC(TURN), .WAIT_W(WAIT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_ack  (req_ack),
    .wait_cfg (wait_cfg),
    .bus_in   (bus_in),
    .drv_en   (drv_en),
    .dev_oe   (dev_oe),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rready   (rready),
    .busy     (busy)
  );

  int               cyc = 0;
  int               n_chk = 0;
  int               n_pass = 0;
  bit               rand_data = 1'b0;
  logic [WIDTH-1:0] dev_word = '0;
  logic [WIDTH-1:0] hist [4096];

  // Bus ownership monitor: overlap and turnaround gap between owners.
  bit mon_en = 1'b0;
  int mon_viol = 0;
  int mon_hand = 0;
  int prev_own = 1;
  int gap = 0;

  always @(negedge clk) begin
    if (mon_en && drv_en && dev_oe) mon_viol++;
    if (!drv_en && !dev_oe) begin
      gap++;
    end else begin
      if (mon_en && (dev_oe ? 2 : 1) != prev_own) begin
        mon_hand++;
        if (gap < TURN) mon_viol++;
      end
      prev_own = dev_oe ? 2 : 1;
      gap = 0;
    end
  end

  // The external device drives dev_word while enabled; otherwise the local side parks a value.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rand_data) dev_word = $urandom;
    bus_in = dev_oe ? dev_word : BUS_PARK;
    hist[cyc % 4096] = bus_in;
  endtask

  task automatic do_read(input logic [WAIT_W-1:0] wc, output int lat, output int oe_cyc,
                         output int back, output logic [WIDTH-1:0] got,
                         output logic [WIDTH-1:0] exp);
    int a = -1;
    int r = -1;
    int n = 0;
    back = -1; oe_cyc = 0; got = '0; exp = '1;
    req = 1'b1;
    wait_cfg = wc;
    while (back < 0 && n < 200) begin
      tick();
      n++;
      if (dev_oe) oe_cyc++;
      if (a < 0 && req_ack) begin
        a = cyc;
        req = 1'b0;
        wait_cfg = WAIT_W'($urandom);
      end
      if (a >= 0 && r < 0 && rvalid) begin
        r = cyc;
        got = rdata;
        exp = hist[(r - 1 - SDLY) % 4096];
      end
      if (r >= 0 && drv_en) back = cyc - r;
    end
    req = 1'b0;
    lat = (a >= 0 && r >= 0) ? r - a : -1;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_chk++; if (drv_en !== 1'b1) $display("FAIL reset_drv_en got=%b exp=1", drv_en); else n_pass++;
    n_chk++; if (dev_oe !== 1'b0) $display("FAIL reset_dev_oe got=%b exp=0", dev_oe); else n_pass++;
    n_chk++; if (rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", rvalid); else n_pass++;
    n_chk++; if (rdata !== '0) $display("FAIL reset_rdata got=%h exp=0", rdata); else n_pass++;
    n_chk++; if (req_ack !== 1'b0) $display("FAIL reset_req_ack got=%b exp=0", req_ack); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int lat, oe, back;
    logic [WIDTH-1:0] got, exp;
    rand_data = 1'b0;
    dev_word = 32'hA5A5_1234;
    do_read(4'd3, lat, oe, back, got, exp);
    n_chk++; if (lat != TURN + 3 + 2 + SDLY) $display("FAIL single_latency got=%0d exp=%0d", lat, TURN + 5 + SDLY); else n_pass++;
    n_chk++; if (got !== 32'hA5A5_1234) $display("FAIL single_rdata got=%h exp=a5a51234", got); else n_pass++;
    n_chk++; if (back != TURN) $display("FAIL single_drv_return got=%0d exp=%0d", back, TURN); else n_pass++;
    n_chk++; if (oe != 3 + 2 + SDLY) $display("FAIL single_dev_oe_cycles got=%0d exp=%0d", oe, 5 + SDLY); else n_pass++;
    n_chk++; if (rvalid !== 1'b0) $display("FAIL single_rvalid_clear got=%b exp=0", rvalid); else n_pass++;
  endtask

  task automatic test_wait0();
    int lat, oe, back;
    logic [WIDTH-1:0] got, exp;
    rand_data = 1'b1;
    do_read(4'd0, lat, oe, back, got, exp);
    n_chk++; if (lat != TURN + 2 + SDLY) $display("FAIL wait0_latency got=%0d exp=%0d", lat, TURN + 2 + SDLY); else n_pass++;
    n_chk++; if (oe != 2 + SDLY) $display("FAIL wait0_dev_oe_cycles got=%0d exp=%0d", oe, 2 + SDLY); else n_pass++;
    n_chk++; if (got !== exp) $display("FAIL wait0_rdata got=%h exp=%h", got, exp); else n_pass++;
  endtask

  task automatic test_overlap();
    int lat, oe, back;
    logic [WIDTH-1:0] got, exp;
    logic [WAIT_W-1:0] wc;
    rand_data = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      wc = WAIT_W'($urandom_range(15));
      do_read(wc, lat, oe, back, got, exp);
      n_chk++; if (lat != TURN + int'(wc) + 2 + SDLY) $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, lat, TURN + int'(wc) + 2 + SDLY); else n_pass++;
      n_chk++; if (got !== exp) $display("FAIL rand_rdata[%0d] got=%h exp=%h", i, got, exp); else n_pass++;
      repeat ($urandom_range(2)) tick();
    end
    mon_en = 1'b0;
    n_chk++; if (mon_viol != 0) $display("FAIL overlap_violations got=%0d exp=0", mon_viol); else n_pass++;
    n_chk++; if (mon_hand != 400) $display("FAIL overlap_handovers got=%0d exp=400", mon_hand); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] hold;
    int a2;
    rand_data = 1'b0;
    dev_word = $urandom;
    wait_cfg = 4'd2;
    req = 1'b1;
    for (int i = 0; i < 100 && !rvalid; i++) tick();
    n_chk++; if (rvalid !== 1'b1) $display("FAIL bp_first_rvalid got=%b exp=1", rvalid); else n_pass++;
    hold = rdata;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++; if (rdata !== hold) $display("FAIL bp_rdata_stable[%0d] got=%h exp=%h", i, rdata, hold); else n_pass++;
      n_chk++; if (req_ack !== 1'b0) $display("FAIL bp_no_ack[%0d] got=%b exp=0", i, req_ack); else n_pass++;
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    a2 = cyc;
    n_chk++; if (rvalid !== 1'b0) $display("FAIL bp_rvalid_clear got=%b exp=0", rvalid); else n_pass++;
    n_chk++; if (req_ack !== 1'b1) $display("FAIL bp_second_ack got=%b exp=1", req_ack); else n_pass++;
    req = 1'b0;
    for (int i = 0; i < 100 && !rvalid; i++) tick();
    n_chk++; if (cyc - a2 != TURN + 2 + 2 + SDLY) $display("FAIL bp_second_latency got=%0d exp=%0d", cyc - a2, TURN + 4 + SDLY); else n_pass++;
    n_chk++; if (rdata !== dev_word) $display("FAIL bp_second_rdata got=%h exp=%h", rdata, dev_word); else n_pass++;
    rready = 1'b1;
    tick();
    rready = 1'b0;
    for (int i = 0; i < 50 && !drv_en; i++) tick();
  endtask

  task automatic test_reset_mid();
    int lat, oe, back;
    logic [WIDTH-1:0] got, exp;
    rand_data = 1'b1;
    wait_cfg = 4'd10;
    req = 1'b1;
    for (int i = 0; i < 100 && !dev_oe; i++) tick();
    req = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    n_chk++; if (dev_oe !== 1'b0) $display("FAIL midrst_dev_oe got=%b exp=0", dev_oe); else n_pass++;
    n_chk++; if (drv_en !== 1'b1) $display("FAIL midrst_drv_en got=%b exp=1", drv_en); else n_pass++;
    n_chk++; if (rvalid !== 1'b0) $display("FAIL midrst_rvalid got=%b exp=0", rvalid); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL midrst_busy got=%b exp=0", busy); else n_pass++;
    rst_n = 1'b1;
    tick();
    do_read(4'd5, lat, oe, back, got, exp);
    n_chk++; if (lat != TURN + 5 + 2 + SDLY) $display("FAIL postrst_latency got=%0d exp=%0d", lat, TURN + 7 + SDLY); else n_pass++;
    n_chk++; if (got !== exp) $display("FAIL postrst_rdata got=%h exp=%h", got, exp); else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_wait0();
    test_overlap();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
